shift_frame_collector: RTL and testbench
========================================

# shift_frame_collector

Serial-to-parallel collector placed directly downstream of the 8-bit shift register. Samples the shifter's serial output bit on every qualified shift, assembles fixed-width frames, and queues completed words in a small FIFO with a valid/ready output handshake. Lets a downstream consumer read whole bytes without tracking shift operations itself.

## Interface
- WIDTH, 8: data bits per frame.
- DEPTH, 2: output FIFO entries, power of two, 2..8.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  serial bit from the shifter's shift output.
- bit_valid  input  1  sample serial_in this cycle (high on each cycle the shifter performs a shift).
- msb_first  input  1  1: first bit received lands in bit WIDTH-1; 0: first bit lands in bit 0. Sampled only on the first bit of a frame.
- flush  input  1  discard the partial frame; does not touch the FIFO.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- bit_count  output  4  bits collected in the current partial frame.
- overflow  output  1  sticky: a completed frame was dropped.
- parity_err  output  1  sticky parity error (see Configuration).

## Operation
- Reset: bit_count=0, out_valid=0, out_data=0, overflow=0, parity_err=0, FIFO empty, state IDLE.
- FSM states:
  - IDLE: bit_count=0. On bit_valid, latch msb_first for the frame, store the first bit, bit_count=1, go to COLLECT.
  - COLLECT: each bit_valid stores one bit and increments bit_count. On the bit that makes bit_count==WIDTH: without parity, push the frame and go to IDLE; with parity, go to PARITY.
  - PARITY (macro only): next bit_valid is the parity bit. Check, push the frame, go to IDLE.
- Bit placement: msb_first=1 shifts left (new bit into bit 0, first bit ends at WIDTH-1); msb_first=0 shifts right (new bit into WIDTH-1, first bit ends at bit 0).
- Push rule: accepted if FIFO not full, or if the FIFO is full and a pop occurs in the same cycle (simultaneous push+pop at full keeps count at DEPTH). Otherwise the frame is dropped and overflow set; it stays set until rst.
- Pop: out_valid && out_ready advances the read pointer. Pop on empty is ignored.
- Pointers wrap modulo DEPTH; count held in a separate log2(DEPTH)+1-bit counter.
- flush: next state IDLE, bit_count=0, partial frame discarded. flush has priority over a bit_valid in the same cycle; that bit is lost. FIFO contents and sticky flags are unchanged.
- rst mid-frame or with a non-empty FIFO: everything returns to reset values on that edge. Queued words are lost.

## Timing
- The last-bit sample edge writes the FIFO; out_valid rises in the following cycle (out_valid is high one cycle after the edge). Latency from the last bit_valid cycle to out_valid=1 is 1 cycle.
- out_data is registered from FIFO storage. It is valid whenever out_valid=1 and holds stable until popped.
- bit_valid may be high on consecutive cycles. The block sustains one bit per cycle with no bubbles between frames.
- bit_count updates on the same edge that samples the bit.
- overflow and parity_err assert on the edge of the offending push.

## Configuration
- SHIFT_COLLECT_PARITY_EN defined: each frame is WIDTH data bits followed by one even-parity bit, handled in the PARITY state. If the XOR of the data bits and the parity bit is 1, parity_err is set (sticky). The word is still pushed. bit_count reads WIDTH while waiting for parity.
- Not defined: no PARITY state, frames are WIDTH bits, and parity_err is tied to 0.

## Test plan
- Basic MSB-first: rst, then msb_first=1, feed bits 0,0,0,1,0,0,1,1 on 8 consecutive bit_valid cycles -> out_valid=1 one cycle after the 8th, out_data=0x13, bit_count=0.
- LSB-first: msb_first=0, same bit sequence -> out_data=0xC8.
- Backpressure/overflow (DEPTH=2): out_ready=0, send 3 frames 0x13, 0xA5, 0xFF -> FIFO holds 0x13 and 0xA5, overflow=1. Then out_ready=1 -> reads 0x13 then 0xA5, then out_valid=0.
- Full with simultaneous pop: FIFO full (0x01, 0x02), and a third frame 0x03 completes in the same cycle as a pop -> overflow stays 0, subsequent reads give 0x02, 0x03.
- Flush/reset mid-frame: 5 bits fed, then flush (with bit_valid=1) -> bit_count=0. A new 8-bit frame of 0x5A yields out_data=0x5A. Repeat with rst instead -> all outputs return to 0.
- Parity (macro defined): frame 0x13 with parity bit 1 -> parity_err=0. Frame 0x13 with parity bit 0 -> parity_err=1, and the word is still delivered.

Source files
------------

// File: rtl/shift_frame_collector.sv
// Serial-to-parallel frame collector with a small valid/ready output FIFO; 1 cycle last bit -> out_valid.
// Backpressure: a completed frame is dropped (sticky overflow) when the FIFO is full and not popping.
// Optional SHIFT_COLLECT_PARITY_EN: each frame carries a trailing even-parity bit checked into parity_err.
module shift_frame_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             msb_first,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       bit_count,
    output logic             overflow,
    output logic             parity_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [3:0]    FRAME_BITS = 4'(WIDTH);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, shifted;
    logic             frame_msb, frame_msb_nxt, dir;
    logic [3:0]       cnt_nxt;
    logic             push;
    logic [WIDTH-1:0] push_word;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             pop, full, accept;

    assign pop       = out_valid && out_ready;
    assign full      = (count == FULL_CNT);
    assign accept    = push && (!full || pop);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

`ifdef SHIFT_COLLECT_PARITY_EN
    logic par_bad;
`endif

    always_comb begin
        // Direction is taken live on the first bit, then from the per-frame latch.
        dir           = (state == IDLE) ? msb_first : frame_msb;
        shifted       = dir ? {sreg[WIDTH-2:0], serial_in} : {serial_in, sreg[WIDTH-1:1]};
        state_nxt     = state;
        sreg_nxt      = sreg;
        frame_msb_nxt = frame_msb;
        cnt_nxt       = bit_count;
        push          = 1'b0;
        push_word     = shifted;
`ifdef SHIFT_COLLECT_PARITY_EN
        par_bad       = 1'b0;
`endif
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (bit_valid) begin
            case (state)
                IDLE, COLLECT: begin
                    sreg_nxt  = shifted;
                    cnt_nxt   = bit_count + 4'd1;
                    state_nxt = COLLECT;
                    if (state == IDLE) begin
                        frame_msb_nxt = msb_first;
                    end
                    if (cnt_nxt == FRAME_BITS) begin
`ifdef SHIFT_COLLECT_PARITY_EN
                        state_nxt = PARITY;
`else
                        push      = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
`endif
                    end
                end
`ifdef SHIFT_COLLECT_PARITY_EN
                PARITY: begin
                    push      = 1'b1;
                    push_word = sreg;
                    par_bad   = ^{sreg, serial_in};
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            frame_msb <= 1'b0;
            bit_count <= '0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            frame_msb <= frame_msb_nxt;
            bit_count <= cnt_nxt;
        end
    end

    // When full, wr_ptr == rd_ptr; a concurrent pop frees that slot as the new tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SHIFT_COLLECT_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (push && par_bad) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_frame_collector.sv
// Bench for shift_frame_collector: directed scenarios plus random traffic against a queue-based model.
module tb_shift_frame_collector;
    localparam int W     = 8;
    localparam int DEPTH = 2;
`ifdef SHIFT_COLLECT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk;
    logic         rst;
    logic         serial_in;
    logic         bit_valid;
    logic         msb_first;
    logic         flush;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   bit_count;
    logic         overflow;
    logic         parity_err;

    shift_frame_collector #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .msb_first  (msb_first),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bit_count  (bit_count),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bits of the current frame, queued words, sticky flags.
    bit           fb[$];
    bit           fmsb;
    logic [W-1:0] mq[$];
    bit           m_ovf;
    bit           m_perr;
    bit           was_rst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit           pop;
        bit           dopush;
        bit           x;
        logic [W-1:0] word;
        pop     = 1'b0;
        dopush  = 1'b0;
        word    = '0;
        was_rst = rst;
        if (rst) begin
            fb.delete();
            mq.delete();
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end else begin
            pop = out_ready && (mq.size() > 0);
            if (flush) begin
                fb.delete();
            end else if (bit_valid) begin
                if (fb.size() == 0) fmsb = msb_first;
                fb.push_back(serial_in);
                if (fb.size() == W + PAR) begin
                    x = 1'b0;
                    for (int i = 0; i < W; i++) begin
                        if (fmsb) word[W-1-i] = fb[i];
                        else      word[i]     = fb[i];
                    end
                    for (int i = 0; i < W + PAR; i++) x = x ^ fb[i];
                    if (PAR == 1 && x) m_perr = 1'b1;
                    dopush = 1'b1;
                    fb.delete();
                end
            end
            if (pop) void'(mq.pop_front());
            if (dopush) begin
                if (mq.size() < DEPTH) mq.push_back(word);
                else                   m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0)  chk("out_data", {24'd0, out_data}, {24'd0, mq[0]});
        else if (was_rst)    chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("bit_count", {28'd0, bit_count}, fb.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
    endtask

    task automatic step(input logic bv, input logic b, input logic m,
                        input logic fl, input logic rdy, input logic r);
        bit_valid = bv;
        serial_in = b;
        msb_first = m;
        flush     = fl;
        out_ready = rdy;
        rst       = r;
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic send_byte(input logic [W-1:0] val, input logic m,
                             input logic rdy, input logic rdy_last);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = m ? val[W-1-i] : val[i];
            step(1'b1, b, m, 1'b0, (PAR == 0 && i == W - 1) ? rdy_last : rdy, 1'b0);
        end
`ifdef SHIFT_COLLECT_PARITY_EN
        step(1'b1, ^val, m, 1'b0, rdy_last, 1'b0);
`endif
    endtask

    task automatic pop_chk(input string tag, input logic [W-1:0] exp);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, {24'd0, out_data}, {24'd0, exp});
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [W-1:0] pat;
        logic         r, fl, rdy;
        bit_valid = 0; serial_in = 0; msb_first = 0; flush = 0; out_ready = 0; rst = 1;
        fmsb = 0; m_ovf = 0; m_perr = 0; was_rst = 0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_count", {28'd0, bit_count}, 32'd0);

        // Bits 0,0,0,1,0,0,1,1 in both orders.
        pat = 8'b0001_0011;
        send_byte(pat, 1'b1, 1'b0, 1'b0);
        chk("msb_first_word", {24'd0, out_data}, 32'h13);
        chk("msb_first_count", {28'd0, bit_count}, 32'd0);
        pop_chk("msb_pop", 8'h13);
        send_byte(8'hC8, 1'b0, 1'b0, 1'b0);
        pop_chk("lsb_first_word", 8'hC8);

        // Overflow under backpressure.
        step(0, 0, 0, 0, 0, 1);
        send_byte(8'h13, 1'b1, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        pop_chk("ovf_rd0", 8'h13);
        pop_chk("ovf_rd1", 8'hA5);
        chk("ovf_drained", {31'd0, out_valid}, 32'd0);

        // Push into a full FIFO on the same edge as a pop.
        step(0, 0, 0, 0, 0, 1);
        send_byte(8'h01, 1'b1, 1'b0, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0, 1'b0);
        send_byte(8'h03, 1'b1, 1'b0, 1'b1);
        chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
        pop_chk("full_pop_rd0", 8'h02);
        pop_chk("full_pop_rd1", 8'h03);

        // Flush mid-frame, with a bit_valid that must be lost.
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);
        chk("partial_count", {28'd0, bit_count}, 32'd5);
        step(1, 1, 1, 1, 0, 0);
        chk("flush_count", {28'd0, bit_count}, 32'd0);
        send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
        pop_chk("after_flush", 8'h5A);

        // Reset mid-frame with a queued word.
        send_byte(8'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_data", {24'd0, out_data}, 32'd0);
        chk("rst_mid_count", {28'd0, bit_count}, 32'd0);
        send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
        pop_chk("after_rst", 8'h5A);

`ifdef SHIFT_COLLECT_PARITY_EN
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < W; i++) step(1, pat[W-1-i], 1, 0, 0, 0);
        chk("parity_wait_count", {28'd0, bit_count}, W);
        step(1, 1, 1, 0, 0, 0);
        chk("parity_good", {31'd0, parity_err}, 32'd0);
        pop_chk("parity_good_word", 8'h13);
        for (int i = 0; i < W; i++) step(1, pat[W-1-i], 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("parity_bad", {31'd0, parity_err}, 32'd1);
        pop_chk("parity_bad_word", 8'h13);
`endif

        // Random traffic with occasional flush/reset and varying backpressure.
        for (int e = 0; e < 40; e++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                r   = ($urandom_range(0, 399) == 0);
                fl  = ($urandom_range(0, 47) == 0);
                rdy = ($urandom_range(0, 99) < rdy_pct);
                step(($urandom % 4) != 0, $urandom % 2, $urandom % 2, fl, rdy, r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
